// File: rtl/toggle_clock_monitor_pkg.sv
// Shared definitions for the toggling-clock monitor and the clock generator
// that produces the divided clock it observes.
package toggle_clock_pkg;

  // Lock state of the monitored slow clock.
  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCKED = 2'd1,
    LOST   = 2'd2
  } mon_state_t;

  // Default divider settings; generator and monitor both use these.
  localparam int unsigned CLK_DIV_HALF  = 75000000;
  localparam int unsigned CLK_DIV_CNT_W = 27;

  // 8-bit increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/toggle_clock_monitor_sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous level, followed by a
// previous-value register and registered one-cycle rise/fall strobes.
// Latency from input change to strobe is three clk_signal cycles.
module sync_edge_detect (
  input  logic clk_signal,
  input  logic reset,
  input  logic async_in,
  output logic rise_pulse,
  output logic fall_pulse
);

  logic sync_meta;
  logic sync_level;
  logic prev_level;

  // Synchronise, remember the previous level and register the edge strobes.
  always_ff @(posedge clk_signal) begin
    if (reset) begin
      sync_meta  <= 1'b0;
      sync_level <= 1'b0;
      prev_level <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      sync_meta  <= async_in;
      sync_level <= sync_meta;
      prev_level <= sync_level;
      rise_pulse <= sync_level & ~prev_level;
      fall_pulse <= ~sync_level & prev_level;
    end
  end

endmodule

// File: rtl/toggle_clock_monitor.sv
// Monitors a slow toggling clock in the clk_signal domain: edge strobes,
// half-period measurement and a SEARCH/LOCKED/LOST lock tracker.
// Optional sticky fault interrupt: define TOGGLE_CLOCK_MONITOR_IRQ_EN.
module toggle_clock_monitor
  import toggle_clock_pkg::*;
#(
  parameter int unsigned CNT_W    = CLK_DIV_CNT_W,
  parameter int unsigned EXP_HALF = CLK_DIV_HALF,
  parameter int unsigned TOL      = 1000,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic             clk_signal,
  input  logic             reset,
  input  logic             clk_in,
`ifdef TOGGLE_CLOCK_MONITOR_IRQ_EN
  input  logic             irq_clr,
  output logic             irq,
`endif
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             locked,
  output logic             lost,
  output logic [CNT_W-1:0] last_half,
  output logic [7:0]       err_count
);

  localparam logic [CNT_W-1:0] LO_BOUND = CNT_W'(EXP_HALF - TOL);
  localparam logic [CNT_W-1:0] HI_BOUND = CNT_W'(EXP_HALF + TOL);
  localparam int unsigned      RUN_W    = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
  localparam logic [RUN_W-1:0] RUN_TOP  = RUN_W'(LOCK_CNT - 1);

  mon_state_t       state;
  logic [CNT_W-1:0] half_cnt;
  logic [CNT_W-1:0] meas;
  logic [RUN_W-1:0] good_run;
  logic             seen_edge;
  logic             edge_evt;
  logic             good;
  logic             timeout;
  logic             lock_fault;
  logic             fault;

  sync_edge_detect u_sync (
    .clk_signal (clk_signal),
    .reset      (reset),
    .async_in   (clk_in),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  // The registered strobes mark the edge cycle; timeout yields to a coincident edge.
  assign edge_evt   = rise_pulse | fall_pulse;
  assign meas       = (&half_cnt) ? half_cnt : half_cnt + 1'b1;
  assign good       = (meas >= LO_BOUND) && (meas <= HI_BOUND);
  assign timeout    = !edge_evt && (state != LOST) && (half_cnt == HI_BOUND);
  assign lock_fault = edge_evt && seen_edge && (state == LOCKED) && !good;
  assign fault      = timeout || lock_fault;

  // Half-period counter: restart on each edge, saturate otherwise.
  always_ff @(posedge clk_signal) begin
    if (reset) begin
      half_cnt  <= '0;
      last_half <= '0;
    end else if (edge_evt) begin
      half_cnt  <= '0;
      last_half <= meas;
    end else if (!(&half_cnt)) begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

  // Lock state machine with registered locked/lost decodes and fault count.
  always_ff @(posedge clk_signal) begin
    if (reset) begin
      state     <= SEARCH;
      good_run  <= '0;
      seen_edge <= 1'b0;
      locked    <= 1'b0;
      lost      <= 1'b0;
      err_count <= '0;
    end else begin
      if (fault) begin
        err_count <= sat_inc8(err_count);
      end
      if (timeout) begin
        state     <= LOST;
        locked    <= 1'b0;
        lost      <= 1'b1;
        seen_edge <= 1'b0;
        good_run  <= '0;
      end else if (edge_evt) begin
        if (!seen_edge) begin
          // First edge only opens a measurement window (also the exit from LOST).
          seen_edge <= 1'b1;
          state     <= SEARCH;
          lost      <= 1'b0;
        end else begin
          case (state)
            SEARCH: begin
              if (!good) begin
                good_run <= '0;
              end else if (good_run == RUN_TOP) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                good_run <= '0;
              end else begin
                good_run <= good_run + 1'b1;
              end
            end
            LOCKED: begin
              if (!good) begin
                state    <= SEARCH;
                locked   <= 1'b0;
                good_run <= '0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

`ifdef TOGGLE_CLOCK_MONITOR_IRQ_EN
  // Sticky fault interrupt; a new fault overrides a simultaneous clear.
  always_ff @(posedge clk_signal) begin
    if (reset) begin
      irq <= 1'b0;
    end else if (fault) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule
